// File: rtl/apb_arb2.sv
// Two-master APB arbiter sharing one downstream APB slave, one transfer at a time.
// Define APB_ARB_RR_EN for round-robin arbitration; default is fixed priority (S0 wins).
module apb_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          S0_PSEL,
    input  logic          S0_PENABLE,
    input  logic [AW-1:0] S0_PADDR,
    input  logic          S0_PWRITE,
    input  logic [DW-1:0] S0_PWDATA,
    output logic [DW-1:0] S0_PRDATA,
    output logic          S0_PREADY,
    output logic          S0_PSLVERR,
    input  logic          S1_PSEL,
    input  logic          S1_PENABLE,
    input  logic [AW-1:0] S1_PADDR,
    input  logic          S1_PWRITE,
    input  logic [DW-1:0] S1_PWDATA,
    output logic [DW-1:0] S1_PRDATA,
    output logic          S1_PREADY,
    output logic          S1_PSLVERR,
    output logic          M_PSEL,
    output logic          M_PENABLE,
    output logic [AW-1:0] M_PADDR,
    output logic          M_PWRITE,
    output logic [DW-1:0] M_PWDATA,
    input  logic [DW-1:0] M_PRDATA,
    input  logic          M_PREADY,
    input  logic          M_PSLVERR,
    output logic          M_GNT
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   any_req, win;
    logic                   psel_nxt, pen_nxt, wr_nxt, gnt_nxt;
    logic [AW-1:0]          addr_nxt;
    logic [DW-1:0]          wdata_nxt;
    logic [1:0]             rdy, rdy_nxt, err, err_nxt;
    logic [1:0][DW-1:0]     rdata, rdata_nxt;
`ifdef APB_ARB_RR_EN
    logic                   last, last_nxt;
`endif

    // Requester PENABLE carries no arbitration information; only PSEL counts.
    logic unused;
    assign unused = ^{S0_PENABLE, S1_PENABLE};

    assign any_req = S0_PSEL | S1_PSEL;
`ifdef APB_ARB_RR_EN
    assign win = (S0_PSEL & S1_PSEL) ? ~last : S1_PSEL;
`else
    assign win = ~S0_PSEL;
`endif

    assign S0_PREADY  = rdy[0];
    assign S1_PREADY  = rdy[1];
    assign S0_PRDATA  = rdata[0];
    assign S1_PRDATA  = rdata[1];
    assign S0_PSLVERR = err[0];
    assign S1_PSLVERR = err[1];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PADDR   <= '0;
            M_PWRITE  <= 1'b0;
            M_PWDATA  <= '0;
            M_GNT     <= 1'b0;
            rdy       <= '0;
            rdata     <= '0;
            err       <= '0;
`ifdef APB_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            M_PSEL    <= psel_nxt;
            M_PENABLE <= pen_nxt;
            M_PADDR   <= addr_nxt;
            M_PWRITE  <= wr_nxt;
            M_PWDATA  <= wdata_nxt;
            M_GNT     <= gnt_nxt;
            rdy       <= rdy_nxt;
            rdata     <= rdata_nxt;
            err       <= err_nxt;
`ifdef APB_ARB_RR_EN
            last      <= last_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (M_PREADY) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel_nxt  = M_PSEL;
        pen_nxt   = M_PENABLE;
        addr_nxt  = M_PADDR;
        wr_nxt    = M_PWRITE;
        wdata_nxt = M_PWDATA;
        gnt_nxt   = M_GNT;
        rdy_nxt   = rdy;
        rdata_nxt = rdata;
        err_nxt   = err;
`ifdef APB_ARB_RR_EN
        last_nxt  = last;
`endif
        case (state)
            IDLE: if (any_req) begin
                gnt_nxt   = win;
`ifdef APB_ARB_RR_EN
                last_nxt  = win;
`endif
                psel_nxt  = 1'b1;
                pen_nxt   = 1'b0;
                addr_nxt  = win ? S1_PADDR  : S0_PADDR;
                wr_nxt    = win ? S1_PWRITE : S0_PWRITE;
                wdata_nxt = win ? S1_PWDATA : S0_PWDATA;
            end
            SETUP: pen_nxt = 1'b1;
            ACCESS: if (M_PREADY) begin
                psel_nxt           = 1'b0;
                pen_nxt            = 1'b0;
                addr_nxt           = '0;
                wr_nxt             = 1'b0;
                wdata_nxt          = '0;
                rdy_nxt[M_GNT]     = 1'b1;
                rdata_nxt[M_GNT]   = M_PWRITE ? '0 : M_PRDATA;
                err_nxt[M_GNT]     = M_PSLVERR;
            end
            DONE: begin
                rdy_nxt   = '0;
                rdata_nxt = '0;
                err_nxt   = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_arb2.sv
// Bench for apb_arb2: transaction-level reference checked every cycle, plus directed literal checks.
module tb_apb_arb2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0, PRESET = 1'b1;
    logic          S0_PSEL = 0, S0_PENABLE = 0, S0_PWRITE = 0;
    logic [AW-1:0] S0_PADDR = '0;
    logic [DW-1:0] S0_PWDATA = '0, S0_PRDATA;
    logic          S0_PREADY, S0_PSLVERR;
    logic          S1_PSEL = 0, S1_PENABLE = 0, S1_PWRITE = 0;
    logic [AW-1:0] S1_PADDR = '0;
    logic [DW-1:0] S1_PWDATA = '0, S1_PRDATA;
    logic          S1_PREADY, S1_PSLVERR;
    logic          M_PSEL, M_PENABLE, M_PWRITE, M_GNT;
    logic [AW-1:0] M_PADDR;
    logic [DW-1:0] M_PWDATA;
    logic [DW-1:0] M_PRDATA = '0;
    logic          M_PREADY = 1'b1, M_PSLVERR = 1'b0;

    apb_arb2 #(.AW(AW), .DW(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .S0_PSEL(S0_PSEL), .S0_PENABLE(S0_PENABLE), .S0_PADDR(S0_PADDR), .S0_PWRITE(S0_PWRITE),
        .S0_PWDATA(S0_PWDATA), .S0_PRDATA(S0_PRDATA), .S0_PREADY(S0_PREADY), .S0_PSLVERR(S0_PSLVERR),
        .S1_PSEL(S1_PSEL), .S1_PENABLE(S1_PENABLE), .S1_PADDR(S1_PADDR), .S1_PWRITE(S1_PWRITE),
        .S1_PWDATA(S1_PWDATA), .S1_PRDATA(S1_PRDATA), .S1_PREADY(S1_PREADY), .S1_PSLVERR(S1_PSLVERR),
        .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR),
        .M_GNT(M_GNT)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding transfer; t counts cycles since grant (1=setup, 2=access).
    bit            mb_busy, mb_done, mb_g, mb_last, mb_gnt, mb_wr, mb_err;
    int            mb_t;
    logic [AW-1:0] mb_addr;
    logic [DW-1:0] mb_wdata, mb_rd;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            mb_busy = 0; mb_done = 0; mb_last = 1; mb_gnt = 0; mb_g = 0;
            mb_rd = '0; mb_err = 0; mb_t = 0;
        end else if (mb_done) begin
            mb_done = 0; mb_busy = 0;
        end else if (mb_busy) begin
            if (mb_t >= 2 && M_PREADY) begin
                mb_done = 1;
                mb_rd   = mb_wr ? '0 : M_PRDATA;
                mb_err  = M_PSLVERR;
            end else mb_t = 2;
        end else if (S0_PSEL || S1_PSEL) begin
`ifdef APB_ARB_RR_EN
            mb_g = (S0_PSEL && S1_PSEL) ? !mb_last : S1_PSEL;
            mb_last = mb_g;
`else
            mb_g = !S0_PSEL;
`endif
            mb_gnt   = mb_g;
            mb_busy  = 1;
            mb_t     = 1;
            mb_addr  = mb_g ? S1_PADDR  : S0_PADDR;
            mb_wr    = mb_g ? S1_PWRITE : S0_PWRITE;
            mb_wdata = mb_g ? S1_PWDATA : S0_PWDATA;
        end
    end

    always @(negedge PCLK) begin
        bit act, d0, d1;
        act = mb_busy && !mb_done;
        d0  = mb_done && !mb_g;
        d1  = mb_done && mb_g;
        chk("M_PSEL", M_PSEL, act);
        chk("M_PENABLE", M_PENABLE, act && mb_t >= 2);
        chk("M_PADDR", M_PADDR, act ? mb_addr : '0);
        chk("M_PWRITE", M_PWRITE, act && mb_wr);
        chk("M_PWDATA", M_PWDATA, act ? mb_wdata : '0);
        chk("M_GNT", M_GNT, mb_gnt);
        chk("S0_PREADY", S0_PREADY, d0);
        chk("S0_PRDATA", S0_PRDATA, d0 ? mb_rd : '0);
        chk("S0_PSLVERR", S0_PSLVERR, d0 && mb_err);
        chk("S1_PREADY", S1_PREADY, d1);
        chk("S1_PRDATA", S1_PRDATA, d1 ? mb_rd : '0);
        chk("S1_PSLVERR", S1_PSLVERR, d1 && mb_err);
    end

    // Slave: ws wait states in ACCESS, error flag only in the completion cycle.
    int            ws = 0, acc = 0;
    logic [DW-1:0] slv_rdata = '0;
    bit            slv_err = 0;
    always @(posedge PCLK) begin
        #1;
        acc       = M_PENABLE ? acc + 1 : 0;
        M_PREADY  = !M_PENABLE || acc > ws;
        M_PSLVERR = slv_err && M_PENABLE && acc > ws;
        M_PRDATA  = slv_rdata;
    end

    bit            wr_cfg[2];
    logic [AW-1:0] base[2];
    logic [DW-1:0] wdat[2];
    int            start_cyc, psel_cyc, pen_cyc, rdy_cyc[2], rdy_cnt[2];
    logic [DW-1:0] seen_rdata[2], setup_wdata;
    bit            seen_err[2];
    bit            gq[$];

    task automatic drive(input int i, input bit sel, input int k);
        if (i == 0) begin
            S0_PSEL = sel; S0_PENABLE = sel; S0_PWRITE = wr_cfg[0];
            S0_PADDR = base[0] + AW'(4 * k); S0_PWDATA = wdat[0] + DW'(k);
        end else begin
            S1_PSEL = sel; S1_PENABLE = sel; S1_PWRITE = wr_cfg[1];
            S1_PADDR = base[1] + AW'(4 * k); S1_PWDATA = wdat[1] + DW'(k);
        end
    endtask

    task automatic run(input int n0, input int n1);
        int n[2], cnt[2], k;
        bit r[2];
        n = '{n0, n1}; cnt = '{0, 0};
        psel_cyc = -1; pen_cyc = -1; rdy_cyc = '{-1, -1}; rdy_cnt = '{0, 0};
        seen_rdata = '{'0, '0}; seen_err = '{0, 0}; gq.delete();
        @(posedge PCLK); #1;
        start_cyc = cyc;
        drive(0, n0 > 0, 0);
        drive(1, n1 > 0, 0);
        k = 0;
        while ((cnt[0] < n[0] || cnt[1] < n[1]) && k < 80) begin
            @(negedge PCLK); k++;
            if (M_PSEL && !M_PENABLE) begin
                gq.push_back(M_GNT);
                if (psel_cyc < 0) begin psel_cyc = cyc; setup_wdata = M_PWDATA; end
            end
            if (M_PENABLE && pen_cyc < 0) pen_cyc = cyc;
            r[0] = S0_PREADY; r[1] = S1_PREADY;
            if (r[0]) begin rdy_cnt[0]++; if (rdy_cyc[0] < 0) rdy_cyc[0] = cyc; seen_rdata[0] = S0_PRDATA; seen_err[0] = S0_PSLVERR; end
            if (r[1]) begin rdy_cnt[1]++; if (rdy_cyc[1] < 0) rdy_cyc[1] = cyc; seen_rdata[1] = S1_PRDATA; seen_err[1] = S1_PSLVERR; end
            @(posedge PCLK); #1;
            for (int i = 0; i < 2; i++)
                if (r[i]) begin cnt[i]++; drive(i, cnt[i] < n[i], cnt[i]); end
        end
        checks++;
        if (k >= 80) begin
            errors++;
            $display("FAIL run_timeout: done %0d/%0d and %0d/%0d transfers", cnt[0], n0, cnt[1], n1);
            drive(0, 0, 0); drive(1, 0, 0);
        end
        repeat (2) @(posedge PCLK);
        #1;
    endtask

    initial begin
        bit exp_order[8];
        int w;
        repeat (2) @(negedge PCLK);
        chk("rst_M_PSEL", M_PSEL, 0);
        chk("rst_M_GNT", M_GNT, 0);
        chk("rst_S0_PREADY", S0_PREADY, 0);
        @(posedge PCLK); #2 PRESET = 0;

        // T1: S0 write 0x8 <= 0xA5, no wait states
        wr_cfg[0] = 1; base[0] = 32'h8; wdat[0] = 32'hA5; ws = 0;
        run(1, 0);
        chk("t1_psel_lat", psel_cyc - start_cyc, 1);
        chk("t1_pen_lat", pen_cyc - start_cyc, 2);
        chk("t1_rdy_lat", rdy_cyc[0] - start_cyc, 3);
        chk("t1_rdy_cnt", rdy_cnt[0], 1);
        chk("t1_s1_rdy", rdy_cnt[1], 0);
        chk("t1_wdata", setup_wdata, 32'hA5);

        // T2: S1 read 0x4 with 3 wait states
        wr_cfg[1] = 0; base[1] = 32'h4; wdat[1] = 32'h0; slv_rdata = 32'h5A; ws = 3;
        run(0, 1);
        chk("t2_rdy_lat", rdy_cyc[1] - start_cyc, 6);
        chk("t2_rdata", seen_rdata[1], 32'h5A);
        chk("t2_s0_rdy", rdy_cnt[0], 0);

        // T3: both request 4 transfers back to back
        wr_cfg = '{1, 1}; base = '{32'h100, 32'h200}; wdat = '{32'h10, 32'h20}; ws = 0;
        run(4, 4);
`ifdef APB_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        chk("t3_grants", gq.size(), 8);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk($sformatf("t3_gnt%0d", i), gq[i], exp_order[i]);

        // T4: read with slave error, then a clean read
        wr_cfg[0] = 0; base[0] = 32'h40; slv_rdata = 32'h33; slv_err = 1; ws = 1;
        run(1, 0);
        chk("t4_err", seen_err[0], 1);
        chk("t4_rdata", seen_rdata[0], 32'h33);
        slv_err = 0;
        run(1, 0);
        chk("t4_err_clear", seen_err[0], 0);

        // T5: reset during ACCESS, then a normal S1 write
        ws = 5; wr_cfg[0] = 0; base[0] = 32'h80;
        @(posedge PCLK); #1 drive(0, 1, 0);
        w = 0;
        do begin @(negedge PCLK); w++; end while (!M_PENABLE && w < 10);
        chk("t5_reached_access", M_PENABLE, 1);
        @(posedge PCLK); #2 PRESET = 1;
        #1;
        chk("t5_M_PSEL", M_PSEL, 0);
        chk("t5_M_PENABLE", M_PENABLE, 0);
        chk("t5_M_PADDR", M_PADDR, 0);
        chk("t5_M_GNT", M_GNT, 0);
        chk("t5_S0_PREADY", S0_PREADY, 0);
        drive(0, 0, 0);
        repeat (2) begin @(negedge PCLK); chk("t5_no_rdy", S0_PREADY, 0); end
        @(posedge PCLK); #2 PRESET = 0;
        ws = 0; wr_cfg[1] = 1; base[1] = 32'h10; wdat[1] = 32'h77;
        run(0, 1);
        chk("t5_s1_rdy_cnt", rdy_cnt[1], 1);
        chk("t5_s1_rdy_lat", rdy_cyc[1] - start_cyc, 3);
        chk("t5_s0_rdy", rdy_cnt[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
